// File: rtl/btn_sampler_pkg.sv
// Shared constants for the button input path: history width, default
// divider and button index map, also used by the downstream debouncers.
package btn_sampler_pkg;

  localparam int STEP_W      = 3;
  localparam int DIV_CNT_DEF = 500000;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CTR   = 4;

endpackage

// File: rtl/btn_shift.sv
// One per-button sample history; shifts the new sample in at the top
// only on sample ticks, so bit STEP_W-1 is the newest and bit 0 the oldest.
module btn_shift
  import btn_sampler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              bit_i,
  output logic [STEP_W-1:0] hist_o
);

  logic [STEP_W-1:0] hist_q;
  logic [STEP_W-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clk_en_i) begin
      hist_d = {bit_i, hist_q[STEP_W-1:1]};
    end else begin
      hist_d = hist_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= {STEP_W{1'b0}};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/btn_sampler.sv
// Button sampler: divides clk into a slow sample tick and keeps a 3-deep
// history per button. Optional macro BTN_SYNC_EN adds a 2-flop input synchronizer.
module btn_sampler
  import btn_sampler_pkg::*;
#(
  parameter int NUM_BTN = 5,
  parameter int DIV_CNT = DIV_CNT_DEF,
  parameter int CNT_W   = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BTN-1:0]        btn_raw,
  output logic                      clk_en,
  output logic                      clk_en_d,
  output logic [STEP_W*NUM_BTN-1:0] step
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CNT - 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               tick_q;
  logic               tick_dly_q;
  logic [NUM_BTN-1:0] btn_in_s;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tick is registered off the terminal count; the delayed copy lines up
  // with the history that the tick just shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      tick_q     <= 1'b0;
      tick_dly_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= (cnt_q == CNT_LAST);
      tick_dly_q <= tick_q;
    end
  end

`ifdef BTN_SYNC_EN
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {NUM_BTN{1'b0}};
      sync2_q <= {NUM_BTN{1'b0}};
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_in_s = sync2_q;
`else
  // Without the synchronizer the newest history bit is the only sync stage.
  assign btn_in_s = btn_raw;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_shift u_shift (
      .clk_i    (clk),
      .rst_i    (rst),
      .clk_en_i (tick_q),
      .bit_i    (btn_in_s[i]),
      .hist_o   (step[STEP_W*i +: STEP_W])
    );
  end

  assign clk_en   = tick_q;
  assign clk_en_d = tick_dly_q;

endmodule

// File: tb/tb_btn_sampler.sv
// Directed bench for btn_sampler: DIV_CNT=4 main instance plus a DIV_CNT=1
// instance sharing clock, reset and buttons.
module tb_btn_sampler;
  import btn_sampler_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  btn_raw;
  logic        clk_en;
  logic        clk_en_d;
  logic [14:0] step;
  logic        clk_en1;
  logic        clk_en_d1;
  logic [14:0] step1;

  int errs;
  int checks;

  btn_sampler #(.NUM_BTN(5), .DIV_CNT(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .clk_en   (clk_en),
    .clk_en_d (clk_en_d),
    .step     (step)
  );

  btn_sampler #(.NUM_BTN(5), .DIV_CNT(1), .CNT_W(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .clk_en   (clk_en1),
    .clk_en_d (clk_en_d1),
    .step     (step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  // Expected 3-bit history of a button held at 1 (at least on tick edges)
  // from just after reset release, DIV_CNT=4: shifts land on edges 5, 9, 13.
  function automatic logic [2:0] held_hist(input int e);
    if (e < 5)       return 3'b000;
    else if (e < 9)  return 3'b100;
    else if (e < 13) return 3'b110;
    else             return 3'b111;
  endfunction

  initial begin
    logic [2:0] tab5 [1:8];
    logic       fire;
    errs    = 0;
    checks  = 0;
    rst     = 1'b1;
    btn_raw = 5'b00000;
    tab5[1] = 3'b000; tab5[2] = 3'b000; tab5[3] = 3'b100; tab5[4] = 3'b010;
    tab5[5] = 3'b101; tab5[6] = 3'b010; tab5[7] = 3'b101; tab5[8] = 3'b010;

    // reset state and idle tick timing
    do_reset();
    check("rst_clk_en",   32'(clk_en),   32'd0);
    check("rst_clk_en_d", 32'(clk_en_d), 32'd0);
    check("rst_step",     32'(step),     32'd0);
    check("rst_step1",    32'(step1),    32'd0);
    for (int e = 1; e <= 13; e++) begin
      edges(1);
      check("idle_clk_en",   32'(clk_en),   32'((e % 4) == 0));
      check("idle_clk_en_d", 32'(clk_en_d), 32'(((e % 4) == 1) && (e > 1)));
      check("idle_step",     32'(step),     32'd0);
    end

    // steady press on button 0 and rising-edge decode
    do_reset();
    btn_raw[BTN_UP] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      edges(1);
      fire = clk_en_d & ~step[0] & step[1];
      check("press_step", 32'(step[2:0]), 32'(held_hist(e)));
      check("press_fire", 32'(fire),      32'(e == 9));
    end

    // bounce on button 3, high at every tick edge
    do_reset();
    btn_raw = 5'b00000;
    for (int e = 1; e <= 13; e++) begin
      btn_raw[BTN_RIGHT] = e[0];
      edges(1);
      check("bounce_step", 32'(step), 32'(15'(held_hist(e)) << 9));
    end

    // mid-count reset with full history
    do_reset();
    btn_raw = 5'b11111;
    edges(14);
    check("full_step", 32'(step), 32'h7FFF);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    check("midrst_step",     32'(step),     32'd0);
    check("midrst_clk_en",   32'(clk_en),   32'd0);
    check("midrst_clk_en_d", 32'(clk_en_d), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      edges(1);
      check("midrst_tick", 32'(clk_en), 32'(e == 4));
      check("midrst_hist", 32'(step), (e == 5) ? 32'h4924 : 32'd0);
    end

    // DIV_CNT=1: tick every clock, button 4 toggling
    do_reset();
    btn_raw = 5'b00000;
    for (int e = 1; e <= 8; e++) begin
      btn_raw[BTN_CTR] = e[0];
      edges(1);
      check("div1_clk_en", 32'(clk_en1), 32'd1);
      check("div1_step",   32'(step1[14:12]), 32'(tab5[e]));
      check("div1_others", 32'(step1[11:0]), 32'd0);
    end

    // button 1 rises one clock before the tick at edge 9
    do_reset();
    btn_raw = 5'b00000;
    edges(8);
    btn_raw[BTN_DOWN] = 1'b1;
    for (int e = 9; e <= 13; e++) begin
      edges(1);
`ifdef BTN_SYNC_EN
      check("late_step", 32'(step[5:3]), (e < 13) ? 32'd0 : 32'b100);
`else
      check("late_step", 32'(step[5:3]), (e < 13) ? 32'b100 : 32'b110);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
